// File: rtl/line_draw_bresenham.sv
// Integer Bresenham line walker. One segment per start request; emits one
// framebuffer pixel write per non-stalled DRAW cycle and reports busy/done
// back to the line sequencer. Pixels outside the active area are walked but
// not written, so wrapped endpoints cannot corrupt memory.
//
// Handshake: oWE is the pixel valid; iStall is the inverse of ready. A pixel
// is accepted on a rising clock edge where oWE-cycle (DRAW) and iStall=0;
// while iStall=1 the shown pixel, oWE and all walker state hold unchanged.
module line_draw_bresenham #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iStart,
  input  logic [9:0] iX1,
  input  logic [8:0] iY1,
  input  logic [9:0] iX2,
  input  logic [8:0] iY2,
  input  logic       iStall,
  output logic [9:0] oX,
  output logic [8:0] oY,
  output logic       oWE,
  output logic       oBusy,
  output logic       oDone
);

  // SETUP is the one-cycle gap after an accepted start: endpoints and
  // deltas are already latched, the first pixel appears the cycle after.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [8:0] V_LIM = 9'(V_ACTIVE);

  state_t             state_q, state_d;
  logic        [9:0]  x_q, x_d, x_end_q, x_end_d;
  logic        [8:0]  y_q, y_d, y_end_q, y_end_d;
  logic        [9:0]  dx_q, dx_d;
  logic        [8:0]  dy_q, dy_d;
  logic               sx_q, sx_d;   // 1: step +1, 0: step -1
  logic               sy_q, sy_d;
  logic signed [11:0] err_q, err_d;
  logic               we_q, we_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Combinational walker helpers
  logic signed [12:0] e2;
  logic signed [12:0] dx_s13, dy_s13;
  logic               step_x, step_y;
  logic        [9:0]  x_n, dx_abs;
  logic        [8:0]  y_n, dy_abs;
  logic signed [11:0] err_n;
  logic               at_end;

  function automatic logic in_range(input logic [9:0] px, input logic [8:0] py);
    return (px < H_LIM) && (py < V_LIM);
  endfunction

  assign oX    = x_q;
  assign oY    = y_q;
  assign oWE   = we_q;
  assign oBusy = busy_q;
  assign oDone = done_q;

  // Next-state and next-register values for the whole walker
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x_end_d = x_end_q;
    y_end_d = y_end_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    err_d   = err_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Both step tests use the old err; e2 is 13 bits so 2*err never overflows.
    e2     = {err_q, 1'b0};
    dx_s13 = $signed({3'b000, dx_q});
    dy_s13 = $signed({4'b0000, dy_q});
    step_x = (e2 > -dy_s13);
    step_y = (e2 < dx_s13);
    at_end = (x_q == x_end_q) && (y_q == y_end_q);

    x_n   = x_q;
    y_n   = y_q;
    err_n = err_q;
    if (step_x) begin
      err_n = err_n - $signed({3'b000, dy_q});
      x_n   = sx_q ? (x_q + 10'd1) : (x_q - 10'd1);
    end
    if (step_y) begin
      err_n = err_n + $signed({2'b00, dx_q});
      y_n   = sy_q ? (y_q + 9'd1) : (y_q - 9'd1);
    end

    dx_abs = (iX2 >= iX1) ? (iX2 - iX1) : (iX1 - iX2);
    dy_abs = (iY2 >= iY1) ? (iY2 - iY1) : (iY1 - iY2);

    case (state_q)
      IDLE: begin
        if (iStart) begin
          x_d     = iX1;
          y_d     = iY1;
          x_end_d = iX2;
          y_end_d = iY2;
          dx_d    = dx_abs;
          dy_d    = dy_abs;
          sx_d    = (iX2 >= iX1);
          sy_d    = (iY2 >= iY1);
          err_d   = $signed({2'b00, dx_abs}) - $signed({3'b000, dy_abs});
          we_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        we_d    = in_range(x_q, y_q);
        state_d = DRAW;
      end
      DRAW: begin
        if (!iStall) begin
          if (at_end) begin
            we_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            x_d   = x_n;
            y_d   = y_n;
            err_d = err_n;
            we_d  = in_range(x_n, y_n);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        we_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous active-low reset wins
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      err_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      err_q   <= err_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule
